// File: rtl/serving_wb_decoder_if.sv
// Wishbone bundle between the CPU/slave environment and serving_wb_decoder.
// master: the CPU plus the slave devices; slave: the decoder itself.
interface serving_wb_decoder_if #(
   parameter int unsigned N_SLV = 2
);
   logic [31:0]         cpu_adr;
   logic [31:0]         cpu_dat;
   logic [3:0]          cpu_sel;
   logic                cpu_we;
   logic                cpu_stb;
   logic [31:0]         cpu_rdt;
   logic                cpu_ack;
   logic                cpu_err;
   logic [31:0]         slv_adr;
   logic [31:0]         slv_dat;
   logic [3:0]          slv_sel;
   logic                slv_we;
   logic [N_SLV-1:0]    slv_stb;
   logic [N_SLV*32-1:0] slv_rdt;
   logic [N_SLV-1:0]    slv_ack;

   modport master (
      output cpu_adr, cpu_dat, cpu_sel, cpu_we, cpu_stb,
      input  cpu_rdt, cpu_ack, cpu_err,
      input  slv_adr, slv_dat, slv_sel, slv_we, slv_stb,
      output slv_rdt, slv_ack
   );

   modport slave (
      input  cpu_adr, cpu_dat, cpu_sel, cpu_we, cpu_stb,
      output cpu_rdt, cpu_ack, cpu_err,
      output slv_adr, slv_dat, slv_sel, slv_we, slv_stb,
      input  slv_rdt, slv_ack
   );
endinterface

// File: rtl/serving_wb_decoder.sv
// Registered Wishbone address decoder/mux: one CPU master, N_SLV base/mask slaves,
// bus-error ack for unmapped addresses, watchdog timeout and saturating error counter.
module serving_wb_decoder #(
   parameter int unsigned         N_SLV    = 2,
   parameter logic [N_SLV*32-1:0] SLV_BASE = {32'h4000_0000, 32'h0000_0000},
   parameter logic [N_SLV*32-1:0] SLV_MASK = {32'hC000_0000, 32'hC000_0000},
   parameter int unsigned         TIMEOUT  = 255,
   parameter logic [31:0]         ERR_RDT  = 32'hDEAD_BEEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   serving_wb_decoder_if.slave  wb_io,
   output logic [7:0]           o_err_cnt
);

   localparam int unsigned SelW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

   typedef enum logic [1:0] {StIdle, StActive, StErr} state_e;

   state_e            state_q, state_d;
   logic [SelW-1:0]   sel_q, sel_d;
   logic [15:0]       wd_q, wd_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              hit;
   logic [SelW-1:0]   hit_idx;
   logic              sel_ack;
   logic [31:0]       sel_rdt;
   logic              wd_expired;
   logic              err_ack;
   logic [N_SLV-1:0]  slv_stb;
   logic              cpu_ack;
   logic              cpu_err;
   logic [31:0]       cpu_rdt;

   // Scan from the top down so the lowest-index hit overwrites the others.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = N_SLV - 1; k >= 0; k--) begin
         if ((wb_io.cpu_adr & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32]) begin
            hit     = 1'b1;
            hit_idx = SelW'(k);
         end
      end
   end

   assign sel_ack    = wb_io.slv_ack[sel_q];
   assign sel_rdt    = wb_io.slv_rdt[{sel_q, 5'd0} +: 32];
   assign wd_expired = (TIMEOUT != 0) && (wd_q == 16'(TIMEOUT));

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      wd_d      = wd_q;
      err_cnt_d = err_cnt_q;
      slv_stb   = '0;
      cpu_ack   = 1'b0;
      cpu_err   = 1'b0;
      cpu_rdt   = sel_rdt;
      err_ack   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (wb_io.cpu_stb) begin
               if (hit) begin
                  sel_d   = hit_idx;
                  wd_d    = '0;
                  state_d = StActive;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StActive: begin
            if (!wb_io.cpu_stb) begin
               state_d = StIdle;
            end else if (sel_ack) begin
               // A slave ack beats a watchdog expiry in the same cycle.
               slv_stb[sel_q] = 1'b1;
               cpu_ack        = 1'b1;
               state_d        = StIdle;
            end else if (wd_expired) begin
               err_ack = 1'b1;
               state_d = StIdle;
            end else begin
               slv_stb[sel_q] = 1'b1;
               wd_d           = wd_q + 16'd1;
            end
         end
         StErr: begin
            err_ack = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (err_ack) begin
         cpu_ack = 1'b1;
         cpu_err = 1'b1;
         cpu_rdt = ERR_RDT;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         sel_q     <= '0;
         wd_q      <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         wd_q      <= wd_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign wb_io.slv_adr = wb_io.cpu_adr;
   assign wb_io.slv_dat = wb_io.cpu_dat;
   assign wb_io.slv_sel = wb_io.cpu_sel;
   assign wb_io.slv_we  = wb_io.cpu_we;
   assign wb_io.slv_stb = slv_stb;
   assign wb_io.cpu_ack = cpu_ack;
   assign wb_io.cpu_err = cpu_err;
   assign wb_io.cpu_rdt = cpu_rdt;
   assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_serving_wb_decoder.sv
// Bench for serving_wb_decoder: table of transactions on two instances (default map,
// and a remapped one with TIMEOUT=8) checked through an expected-result queue.
module tb_serving_wb_decoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serving_wb_decoder_if #(.N_SLV(2)) bus_a ();
   serving_wb_decoder_if #(.N_SLV(2)) bus_b ();
   logic [7:0] cnt_a, cnt_b;

   serving_wb_decoder u_dut_a (
      .i_clk     (clk),
      .i_rst     (rst),
      .wb_io     (bus_a),
      .o_err_cnt (cnt_a)
   );

   serving_wb_decoder #(
      .SLV_BASE ({32'h8000_0000, 32'h0000_0000}),
      .TIMEOUT  (8)
   ) u_dut_b (
      .i_clk     (clk),
      .i_rst     (rst),
      .wb_io     (bus_b),
      .o_err_cnt (cnt_b)
   );

   // Bench-side drive; dsel routes strobe/acks to one instance at a time.
   logic        dsel;
   logic [31:0] cpu_adr, cpu_dat;
   logic [3:0]  cpu_sel;
   logic        cpu_we, cpu_stb;
   logic [63:0] slv_rdt;
   logic [1:0]  slv_ack;

   assign bus_a.cpu_adr = cpu_adr;
   assign bus_a.cpu_dat = cpu_dat;
   assign bus_a.cpu_sel = cpu_sel;
   assign bus_a.cpu_we  = cpu_we;
   assign bus_a.cpu_stb = cpu_stb & ~dsel;
   assign bus_a.slv_rdt = slv_rdt;
   assign bus_a.slv_ack = dsel ? 2'b00 : slv_ack;
   assign bus_b.cpu_adr = cpu_adr;
   assign bus_b.cpu_dat = cpu_dat;
   assign bus_b.cpu_sel = cpu_sel;
   assign bus_b.cpu_we  = cpu_we;
   assign bus_b.cpu_stb = cpu_stb & dsel;
   assign bus_b.slv_rdt = slv_rdt;
   assign bus_b.slv_ack = dsel ? slv_ack : 2'b00;

   logic        m_ack, m_err, m_swe;
   logic [31:0] m_rdt, m_sadr, m_sdat;
   logic [3:0]  m_ssel;
   logic [1:0]  m_stb;
   logic [7:0]  m_cnt;
   assign m_ack  = dsel ? bus_b.cpu_ack : bus_a.cpu_ack;
   assign m_err  = dsel ? bus_b.cpu_err : bus_a.cpu_err;
   assign m_rdt  = dsel ? bus_b.cpu_rdt : bus_a.cpu_rdt;
   assign m_stb  = dsel ? bus_b.slv_stb : bus_a.slv_stb;
   assign m_sadr = dsel ? bus_b.slv_adr : bus_a.slv_adr;
   assign m_sdat = dsel ? bus_b.slv_dat : bus_a.slv_dat;
   assign m_ssel = dsel ? bus_b.slv_sel : bus_a.slv_sel;
   assign m_swe  = dsel ? bus_b.slv_we  : bus_a.slv_we;
   assign m_cnt  = dsel ? cnt_b : cnt_a;

   typedef struct {
      bit          dut;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      bit          we;
      logic [31:0] rdt0;
      logic [31:0] rdt1;
      int          ack_cyc;     // cycle (stb rise = 0) the target slave acks, -1 never
      logic [1:0]  ack_mask;
      int          oth_cyc;     // cycle a stray ack is driven, -1 never
      logic [1:0]  oth_mask;
      logic [1:0]  exp_stb;
      int          exp_stb_cyc;
      int          exp_ack_cyc;
      bit          exp_err;
      logic [31:0] exp_rdt;
   } vec_t;

   typedef struct {
      logic [31:0] rdt;
      bit          err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   model_cnt[2];
   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v);
      exp_t e;
      int   stb_cyc = 0;
      bit   done = 0;
      @(posedge clk); #1;
      dsel    = v.dut;
      cpu_adr = v.adr;
      cpu_dat = v.dat;
      cpu_sel = v.sel;
      cpu_we  = v.we;
      cpu_stb = 1'b1;
      slv_rdt = {v.rdt1, v.rdt0};
      sb.push_back('{rdt: v.exp_rdt, err: v.exp_err, cyc: v.exp_ack_cyc});
      if (v.exp_err && model_cnt[v.dut] < 255) model_cnt[v.dut]++;
      for (int c = 0; c < 30 && !done; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         slv_ack = ((c == v.ack_cyc) ? v.ack_mask : 2'b00) |
                   ((c == v.oth_cyc) ? v.oth_mask : 2'b00);
         #3;
         if (c == 0) begin
            check("slv_stb_cycle0", m_stb, 2'b00);
            check("slv_adr", m_sadr, v.adr);
            check("slv_dat", m_sdat, v.dat);
            check("slv_sel", m_ssel, v.sel);
            check("slv_we", m_swe, v.we);
         end else if (m_stb != 2'b00) begin
            stb_cyc++;
            check("slv_stb_onehot", m_stb, v.exp_stb);
         end
         if (m_ack) begin
            done = 1;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_ack: got ack in cycle %0d, expected none", c);
            end else begin
               e = sb.pop_front();
               check("ack_cycle", c, e.cyc);
               check("ack_err", m_err, e.err);
               check("ack_rdt", m_rdt, e.rdt);
            end
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL ack_wait: got no ack in 30 cycles, expected ack in cycle %0d",
                  v.exp_ack_cyc);
         sb.delete();
      end
      @(posedge clk); #1;
      cpu_stb = 1'b0;
      slv_ack = 2'b00;
      #3;
      check("ack_after_idle", m_ack, 1'b0);
      check("stb_cycles", stb_cyc, v.exp_stb_cyc);
      check("err_cnt", m_cnt, model_cnt[v.dut]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish, expected finish before 1 ms");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'h1234_5678, 32'h0,
                  1, 2'b01, -1, 2'b00, 2'b01, 1, 1, 0, 32'h1234_5678};
      vecs[1] = '{0, 32'h4000_0004, 32'hA5A5_A5A5, 4'b0011, 1, 32'h0, 32'h0,
                  4, 2'b10, -1, 2'b00, 2'b10, 4, 4, 0, 32'h0};
      vecs[2] = '{0, 32'hC000_0000, 32'h0, 4'hF, 0, 32'h1111_1111, 32'h2222_2222,
                  -1, 2'b00, -1, 2'b00, 2'b00, 0, 1, 1, 32'hDEAD_BEEF};
      vecs[3] = '{1, 32'h4000_0000, 32'h0, 4'hF, 0, 32'h1111_1111, 32'h2222_2222,
                  -1, 2'b00, -1, 2'b00, 2'b00, 0, 1, 1, 32'hDEAD_BEEF};
      vecs[4] = '{1, 32'h0000_0100, 32'h0, 4'hF, 0, 32'h5555_5555, 32'h0,
                  -1, 2'b00, -1, 2'b00, 2'b01, 8, 9, 1, 32'hDEAD_BEEF};
      vecs[5] = '{1, 32'h0000_0200, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 32'h0,
                  9, 2'b01, -1, 2'b00, 2'b01, 9, 9, 0, 32'hCAFE_F00D};
      vecs[6] = '{0, 32'h4000_0008, 32'h0, 4'hF, 0, 32'h7777_7777, 32'h0BAD_F00D,
                  3, 2'b10, 1, 2'b01, 2'b10, 3, 3, 0, 32'h0BAD_F00D};
      vecs[7] = '{1, 32'h8000_0040, 32'h0, 4'hF, 0, 32'h0, 32'h89AB_CDEF,
                  2, 2'b10, -1, 2'b00, 2'b10, 2, 2, 0, 32'h89AB_CDEF};

      model_cnt[0] = 0;
      model_cnt[1] = 0;
      dsel    = 1'b0;
      cpu_adr = '0;
      cpu_dat = '0;
      cpu_sel = '0;
      cpu_we  = 1'b0;
      cpu_stb = 1'b0;
      slv_rdt = '0;
      slv_ack = '0;
      rst     = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #3;
      check("rst_stb_a", bus_a.slv_stb, 2'b00);
      check("rst_ack_a", bus_a.cpu_ack, 1'b0);
      check("rst_err_a", bus_a.cpu_err, 1'b0);
      check("rst_cnt_a", cnt_a, 8'd0);
      check("rst_stb_b", bus_b.slv_stb, 2'b00);
      check("rst_cnt_b", cnt_b, 8'd0);

      for (int i = 0; i < 8; i++) run(vecs[i]);

      // Strobe withdrawn mid-wait: no ack, no error count.
      @(posedge clk); #1;
      dsel    = 1'b0;
      cpu_adr = 32'h0000_0010;
      cpu_stb = 1'b1;
      slv_ack = 2'b00;
      @(posedge clk); #4;
      check("drop_stb_active", m_stb, 2'b01);
      @(posedge clk); #1;
      cpu_stb = 1'b0;
      #3;
      check("drop_stb_released", m_stb, 2'b00);
      check("drop_no_ack", m_ack, 1'b0);
      @(posedge clk); #4;
      check("drop_no_ack_later", m_ack, 1'b0);
      check("drop_cnt", m_cnt, model_cnt[0]);
      run(vecs[0]);

      // Error counter saturation on repeated timeouts.
      for (int i = 0; i < 300; i++) run(vecs[4]);
      check("err_cnt_saturated", cnt_b, 8'd255);

      // Async reset while a slave strobe is active.
      @(posedge clk); #1;
      dsel    = 1'b0;
      cpu_adr = 32'h0000_0010;
      cpu_stb = 1'b1;
      @(posedge clk); #2;
      check("rst_pre_stb", m_stb, 2'b01);
      rst = 1'b1;
      #1;
      check("rst_async_stb", m_stb, 2'b00);
      check("rst_async_ack", m_ack, 1'b0);
      @(posedge clk); #1;
      cpu_stb = 1'b0;
      rst     = 1'b0;
      model_cnt[0] = 0;
      model_cnt[1] = 0;
      #3;
      check("rst_cnt_b_cleared", cnt_b, 8'd0);
      run(vecs[0]);
      run(vecs[7]);

      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
